// File: rtl/tsb_pkg.sv
// Shared definitions for the tri-state bus drive controller.
// FSM encodings and counter widths used by tsb_drive_ctrl.
package tsb_pkg;

    localparam int BEAT_W = 8;
    localparam int TURN_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

endpackage

// File: rtl/tsb_drive_ctrl.sv
// Tri-state bus drive controller: requests the bus, streams beats into
// an external bufif1 array, and releases with turnaround. Optional TSB_PARITY_EN.
module tsb_drive_ctrl
    import tsb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int TURN_CYC  = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [WIDTH-1:0] drv_data,
    output logic             drv_en,
    output logic             gnt_lost
`ifdef TSB_PARITY_EN
    ,
    output logic             drv_par
`endif
);

    localparam logic [BEAT_W-1:0] MAX_B   = BEAT_W'(MAX_BURST);
    localparam logic [TURN_W-1:0] TURN_LD = TURN_W'(TURN_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              drv_en_q;
    logic [WIDTH-1:0]  drv_data_q;
    logic              accept;
    logic              burst_done;

    // Handshake outputs are forced low while reset is held.
    assign in_ready   = !rst && (state_q == ST_DRIVE) && bus_gnt;
    assign bus_req    = !rst && ((state_q == ST_REQ) || (state_q == ST_DRIVE));
    assign gnt_lost   = !rst && (state_q == ST_DRIVE) && !bus_gnt;
    assign accept     = in_valid && in_ready;
    assign burst_done = in_last || ((beat_q + BEAT_W'(1)) == MAX_B);
    assign drv_en     = drv_en_q;
    assign drv_data   = drv_data_q;

    // Next-state logic for the tenure FSM and its beat/turnaround counters.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        turn_d  = turn_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_d = ST_DRIVE;
                    beat_d  = '0;
                end
            end
            ST_DRIVE: begin
                if (!bus_gnt) begin
                    state_d = ST_TURN;
                    turn_d  = TURN_LD;
                end else if (accept) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (burst_done) begin
                        state_d = ST_TURN;
                        turn_d  = TURN_LD;
                    end
                end
            end
            ST_TURN: begin
                if (turn_q == '0) state_d = ST_IDLE;
                else              turn_d  = turn_q - TURN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the registered bufif1 data/enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            turn_q     <= '0;
            drv_en_q   <= 1'b0;
            drv_data_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            turn_q   <= turn_d;
            drv_en_q <= accept;
            if (accept) drv_data_q <= in_data;
        end
    end

`ifdef TSB_PARITY_EN
    logic par_q;

    // Parity is registered alongside the data word it covers.
    always_ff @(posedge clk) begin
        if (rst)         par_q <= 1'b0;
        else if (accept) par_q <= ^in_data;
    end

    assign drv_par = par_q;
`endif

endmodule
